tile_line_scheduler: RTL and testbench

//  Per-scanline sprite scheduler for the snake VGA display. During horizontal blanking it walks the

---
 rtl/tile_line_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_tile_line_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tile_line_scheduler.sv
// Per-scanline sprite scheduler: builds a 32-tile occupancy line during hblank from the food and
// snake lists, then answers per pixel which sprite covers the current 20x20 tile and its ROM address.
`timescale 1ns/1ps
module tile_line_scheduler #(
  parameter int max_len         = 16,
  parameter int num_len         = 10,
  parameter int max_len_bit_len = 4,
  parameter int width           = 32,
  parameter int height          = 24,
  parameter int H_TRIG          = 640
) (
  input  logic                         vga_clk,
  input  logic                         vga_rst,
  input  logic [9:0]                   row_addr,
  input  logic [9:0]                   col_addr,
  input  logic [max_len*num_len-1:0]   snake1,
  input  logic [max_len*num_len-1:0]   snake2,
  input  logic [max_len_bit_len-1:0]   score1,
  input  logic [max_len_bit_len-1:0]   score2,
  input  logic [num_len-1:0]           food1,
  input  logic [num_len-1:0]           food2,
  output logic [2:0]                   tile_code,
  output logic [8:0]                   pix_addr,
  output logic                         busy,
  output logic                         overrun
);

  localparam int n_entries = 2 + 2 * max_len;
  localparam int idx_w     = $clog2(n_entries);
  localparam int j_w       = $clog2(max_len);
  localparam int col_w     = $clog2(width);
  localparam logic [9:0] last_row   = 10'd524;
  localparam logic [9:0] vis_rows   = 10'd480;
  localparam logic [9:0] vis_cols   = 10'd640;
  localparam logic [9:0] h_trig_col = 10'(H_TRIG);
  localparam logic [9:0] tile_px    = 10'd20;
  localparam logic [num_len-1:0] unused_cell = '1;

  typedef enum logic [1:0] {IDLE, CLEAR, SCAN, DONE} state_t;

  state_t                      state_q, state_d;
  logic                        clear_back, scan_en, swap;
  logic                        at_trig_q, trig, build_ok;
  logic [9:0]                  next_row;
  logic [idx_w-1:0]            idx_q;
  logic [num_len-1:0]          food1_q, food2_q, trow_q;
  logic [max_len_bit_len-1:0]  score1_q, score2_q;
  logic                        front_sel_q, back_sel;
  logic [2:0]                  line_buf [2][width];

  assign next_row = (row_addr == last_row) ? '0 : row_addr + 10'd1;
  assign build_ok = next_row < vis_rows;
  // Edge detect so a col_addr held at the trigger column fires only once.
  assign trig     = (col_addr == h_trig_col) && !at_trig_q;
  assign back_sel = ~front_sel_q;

  always_ff @(posedge vga_clk or negedge vga_rst) begin
    if (!vga_rst) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      CLEAR:   state_d = SCAN;
      SCAN:    if (idx_q == idx_w'(n_entries - 1)) state_d = DONE;
      DONE:    if (col_addr == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (trig) state_d = build_ok ? CLEAR : IDLE;
  end

  always_comb begin
    busy       = (state_q == CLEAR) || (state_q == SCAN);
    clear_back = (state_q == CLEAR);
    scan_en    = (state_q == SCAN);
    swap       = (state_q == DONE) && (col_addr == '0);
  end

  // Entry walk: idx 0 food1, idx 1 food2, then snake1[j]/snake2[j] interleaved.
  logic [idx_w-1:0]   pair;
  logic [j_w-1:0]     j;
  logic               is_s2, live, hit;
  logic [num_len-1:0] entry, entry_row;
  logic [col_w-1:0]   entry_col;
  logic [2:0]         code, stored;

  always_comb begin
    pair  = idx_q - idx_w'(2);
    j     = j_w'(pair >> 1);
    is_s2 = pair[0];
    entry = food1_q;
    code  = 3'd1;
    live  = 1'b1;
    if (idx_q == idx_w'(1)) begin
      entry = food2_q;
      code  = 3'd2;
    end else if (idx_q >= idx_w'(2)) begin
      entry = is_s2 ? snake2[j*num_len +: num_len] : snake1[j*num_len +: num_len];
      if (is_s2) code = (j == '0) ? 3'd6 : 3'd5;
      else       code = (j == '0) ? 3'd4 : 3'd3;
      live  = 32'(j) < 32'(is_s2 ? score2_q : score1_q);
    end
  end

  assign entry_row = entry / num_len'(width);
  assign entry_col = col_w'(entry % num_len'(width));
  assign stored    = line_buf[back_sel][entry_col];
  assign hit       = scan_en && (entry != unused_cell) && (entry_row == trow_q) &&
                     (entry_row < num_len'(height)) && live;

  always_ff @(posedge vga_clk or negedge vga_rst) begin
    if (!vga_rst) begin
      // NOTE: the line buffers are reset explicitly so the first frame never shows stale sprites.
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < width; i++) line_buf[b][i] <= '0;
      front_sel_q <= 1'b0;
    end else begin
      if (clear_back) begin
        for (int i = 0; i < width; i++) line_buf[back_sel][i] <= '0;
      end else if (hit && (code > stored)) begin
        line_buf[back_sel][entry_col] <= code;
      end
      if (swap) front_sel_q <= back_sel;
    end
  end

  always_ff @(posedge vga_clk or negedge vga_rst) begin
    if (!vga_rst) begin
      at_trig_q <= 1'b0;
      overrun   <= 1'b0;
      idx_q     <= '0;
      food1_q   <= '0;
      food2_q   <= '0;
      trow_q    <= '0;
      score1_q  <= '0;
      score2_q  <= '0;
    end else begin
      at_trig_q <= (col_addr == h_trig_col);
      if (trig && (state_q != IDLE)) overrun <= 1'b1;
      if (clear_back) begin
        idx_q    <= '0;
        food1_q  <= food1;
        food2_q  <= food2;
        score1_q <= score1;
        score2_q <= score2;
        trow_q   <= num_len'(next_row / tile_px);
      end else if (scan_en) begin
        idx_q <= idx_q + idx_w'(1);
      end
    end
  end

  // Lookup reads the buffer that is front after this edge, so col 0 already sees the new line.
  logic               look_sel, show;
  logic [col_w-1:0]   tc;
  logic [9:0]         dx_full, dy_full;
  logic [2:0]         front_code;
  logic [8:0]         pix_calc;

  assign look_sel   = front_sel_q ^ swap;
  assign tc         = col_w'(col_addr / tile_px);
  assign dx_full    = col_addr % tile_px;
  assign dy_full    = row_addr % tile_px;
  assign front_code = line_buf[look_sel][tc];
  assign pix_calc   = 9'(10'd19 - dy_full) * 9'd20 + 9'(dx_full);
  assign show       = (row_addr < vis_rows) && (col_addr < vis_cols) && (front_code != '0);

  always_ff @(posedge vga_clk or negedge vga_rst) begin
    if (!vga_rst) begin
      tile_code <= '0;
      pix_addr  <= '0;
    end else begin
      tile_code <= show ? front_code : '0;
      pix_addr  <= show ? pix_calc : '0;
    end
  end

endmodule

// File: tb/tb_tile_line_scheduler.sv
// Directed bench for tile_line_scheduler: table of built lines plus lookups, then hand sequences
// for trigger timing, buffer swap, overrun and mid-build reset.
`timescale 1ns/1ps
module tb_tile_line_scheduler;

  logic         vga_clk = 1'b0;
  logic         vga_rst;
  logic [9:0]   row_addr, col_addr;
  logic [159:0] snake1, snake2;
  logic [3:0]   score1, score2;
  logic [9:0]   food1, food2;
  logic [2:0]   tile_code;
  logic [8:0]   pix_addr;
  logic         busy, overrun;

  int checks = 0;
  int errors = 0;

  always #5 vga_clk = ~vga_clk;

  tile_line_scheduler dut (
    .vga_clk  (vga_clk),
    .vga_rst  (vga_rst),
    .row_addr (row_addr),
    .col_addr (col_addr),
    .snake1   (snake1),
    .snake2   (snake2),
    .score1   (score1),
    .score2   (score2),
    .food1    (food1),
    .food2    (food2),
    .tile_code(tile_code),
    .pix_addr (pix_addr),
    .busy     (busy),
    .overrun  (overrun)
  );

  typedef struct {
    int    scen;
    int    row;
    int    col;
    int    code;
    int    pix;
    string name;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input int s, input int r, input int c, input int code, input int pix,
                         input string name);
    vec_t v;
    v.scen = s; v.row = r; v.col = c; v.code = code; v.pix = pix; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_s1(input int j, input logic [9:0] v);
    snake1[j*10 +: 10] = v;
  endtask

  task automatic set_s2(input int j, input logic [9:0] v);
    snake2[j*10 +: 10] = v;
  endtask

  task automatic set_scenario(input int s);
    snake1 = '1; snake2 = '1; food1 = 10'h3FF; food2 = 10'h3FF; score1 = 0; score2 = 0;
    case (s)
      0: food1 = 10'd33;
      1: begin set_s1(0, 10'd65); set_s1(1, 10'd66); score1 = 2; end
      2: begin set_s1(0, 10'd65); set_s1(1, 10'd66); score1 = 1; end
      3: begin set_s1(0, 10'd0); set_s2(3, 10'd0); food2 = 10'd0; score1 = 1; score2 = 4; end
      4: begin set_s1(0, 10'd0); set_s2(3, 10'd0); food2 = 10'd0; score1 = 1; score2 = 3; end
      5: begin
        set_s2(0, 10'd97); set_s2(1, 10'd98); set_s2(5, 10'h3FF);
        set_s2(6, 10'd99); set_s2(8, 10'd100); score2 = 8;
        food1 = 10'd769;
      end
      default: ;
    endcase
  endtask

  // One hblank build on the row before r, then the wrap to col 0 of row r.
  task automatic build_for(input int r);
    row_addr = (r == 0) ? 10'd524 : 10'(r - 1);
    col_addr = 10'd639; tick();
    col_addr = 10'd640; tick();
    for (int k = 0; k < 40; k++) begin
      col_addr = col_addr + 10'd1;
      tick();
    end
    row_addr = 10'(r);
    col_addr = 10'd0;
    tick();
  endtask

  task automatic lookup(input int r, input int c, input int code, input int pix, input string name);
    row_addr = 10'(r);
    col_addr = 10'(c);
    tick();
    check({name, ".code"}, 32'(tile_code), code);
    check({name, ".pix"},  32'(pix_addr),  pix);
  endtask

  // Advances col by one per cycle until busy drops; returns cycles counted after the trigger edge.
  task automatic count_busy(input int hold, output int n);
    n = 0;
    while (busy && n < 100) begin
      if (n >= hold) col_addr = col_addr + 10'd1;
      tick();
      n++;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;

    add_vec(0, 20,  20, 1, 380, "f1_c20");
    add_vec(0, 20,  39, 1, 399, "f1_c39");
    add_vec(0, 39,  39, 1, 19,  "f1_r39c39");
    add_vec(0, 20,  19, 0, 0,   "f1_left");
    add_vec(0, 20,  40, 0, 0,   "f1_right");
    add_vec(0, 20,  660, 0, 0,  "hblank_col");
    add_vec(0, 480, 20, 0, 0,   "vblank_row");
    add_vec(1, 40,  20, 4, 380, "s1_head");
    add_vec(1, 40,  40, 3, 380, "s1_body");
    add_vec(1, 45,  45, 3, 285, "s1_body_pix");
    add_vec(2, 40,  40, 0, 0,   "score1_cut");
    add_vec(2, 40,  20, 4, 380, "score1_head");
    add_vec(3, 0,   0,  5, 380, "prio_s2body");
    add_vec(3, 0,   5,  5, 385, "prio_pix");
    add_vec(4, 0,   0,  4, 380, "prio_s1head");
    add_vec(5, 60,  20, 6, 380, "s2_head");
    add_vec(5, 60,  40, 5, 380, "s2_body");
    add_vec(5, 60,  60, 5, 380, "s2_j6");
    add_vec(5, 60,  80, 0, 0,   "s2_score_cut");
    add_vec(5, 60,  0,  0, 0,   "s2_empty");

    vga_rst  = 1'b0;
    row_addr = '0;
    col_addr = 10'd100;
    set_scenario(-1);
    tick(); tick(); tick();
    check("rst.tile_code", 32'(tile_code), 0);
    check("rst.pix_addr",  32'(pix_addr),  0);
    check("rst.busy",      32'(busy),      0);
    check("rst.overrun",   32'(overrun),   0);
    vga_rst = 1'b1;
    tick();

    foreach (vecs[i]) begin
      set_scenario(vecs[i].scen);
      build_for(vecs[i].row);
      lookup(vecs[i].row, vecs[i].col, vecs[i].code, vecs[i].pix, vecs[i].name);
    end

    // Trigger timing, held trigger column, swap exactly at col 0.
    set_scenario(0);
    build_for(20);
    food1 = 10'd32;
    row_addr = 10'd19;
    col_addr = 10'd639; tick();
    check("trig.busy_before", 32'(busy), 0);
    col_addr = 10'd640; tick();
    check("trig.busy_rise", 32'(busy), 1);
    count_busy(2, n);
    check("trig.busy_len", n, 35);
    check("trig.no_retrigger", 32'(overrun), 0);
    lookup(19, 20, 1, 0,   "pre_swap");
    lookup(20, 0,  1, 380, "swap_col0");
    lookup(20, 20, 0, 0,   "swap_old_gone");

    // Retrigger mid-build: sticky overrun, restart, front untouched until the next swap.
    food1 = 10'd33;
    row_addr = 10'd19;
    col_addr = 10'd639; tick();
    col_addr = 10'd640; tick();
    for (int k = 0; k < 5; k++) begin
      col_addr = col_addr + 10'd1;
      tick();
    end
    col_addr = 10'd640; tick();
    check("ovr.set", 32'(overrun), 1);
    check("ovr.busy", 32'(busy), 1);
    count_busy(0, n);
    check("ovr.restart_len", n, 35);
    lookup(19, 5,  1, 5,   "ovr.front_kept");
    lookup(20, 0,  0, 0,   "ovr.swap_c0");
    lookup(20, 20, 1, 380, "ovr.swap_c1");
    check("ovr.sticky", 32'(overrun), 1);

    // Asynchronous reset during SCAN.
    row_addr = 10'd19;
    col_addr = 10'd639; tick();
    col_addr = 10'd640; tick();
    for (int k = 0; k < 5; k++) begin
      col_addr = col_addr + 10'd1;
      tick();
    end
    check("rstmid.busy_before", 32'(busy), 1);
    vga_rst = 1'b0;
    #1;
    check("rstmid.busy", 32'(busy), 0);
    check("rstmid.tile_code", 32'(tile_code), 0);
    check("rstmid.overrun", 32'(overrun), 0);
    tick();
    vga_rst = 1'b1;
    lookup(20, 20, 0, 0, "rstmid.buf_cleared");
    check("rstmid.idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
